// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control constants: op classes, opcodes, state encoding, select codes.
// MAIN_CTRL_TRAP_EN adds the TRAP state to the state encoding.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W    = 6;
  localparam int unsigned OP_CLASS_W  = 3;
  localparam int unsigned STATE_ENC_W = 4;
  localparam int unsigned ALU_SRC_B_W = 2;
  localparam int unsigned PC_SOURCE_W = 2;

  // Op classes shared with the ALU control block
  localparam logic [OP_CLASS_W-1:0] OP_CLASS_R  = 3'b000;
  localparam logic [OP_CLASS_W-1:0] OP_CLASS_I  = 3'b001;
  localparam logic [OP_CLASS_W-1:0] OP_CLASS_J  = 3'b010;
  localparam logic [OP_CLASS_W-1:0] OP_CLASS_BR = 3'b011;
  localparam logic [OP_CLASS_W-1:0] OP_CLASS_IF = 3'b100;
  localparam logic [OP_CLASS_W-1:0] OP_CLASS_ID = 3'b101;
  localparam logic [OP_CLASS_W-1:0] OP_CLASS_RS = 3'b110;

  localparam logic [OPCODE_W-1:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OPCODE_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OPCODE_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OPCODE_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OPCODE_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OPCODE_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OPCODE_J     = 6'b000010;

  localparam logic [ALU_SRC_B_W-1:0] ALU_B_REG   = 2'b00;
  localparam logic [ALU_SRC_B_W-1:0] ALU_B_FOUR  = 2'b01;
  localparam logic [ALU_SRC_B_W-1:0] ALU_B_SEXT  = 2'b10;
  localparam logic [ALU_SRC_B_W-1:0] ALU_B_SHIFT = 2'b11;

  localparam logic [PC_SOURCE_W-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [PC_SOURCE_W-1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [PC_SOURCE_W-1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [STATE_ENC_W-1:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BEQ    = 4'd11,
    S_BNE    = 4'd12,
    S_JUMP   = 4'd13
`ifdef MAIN_CTRL_TRAP_EN
    ,
    S_TRAP   = 4'd14
`endif
  } state_e;

  // Datapath control word produced by the output decoder
  typedef struct packed {
    logic [OP_CLASS_W-1:0]  op_class;
    logic                   pc_write;
    logic                   pc_write_cond;
    logic [PC_SOURCE_W-1:0] pc_source;
    logic                   i_or_d;
    logic                   mem_read;
    logic                   mem_write;
    logic                   ir_write;
    logic                   alu_src_a;
    logic [ALU_SRC_B_W-1:0] alu_src_b;
    logic                   reg_write;
    logic                   reg_dst;
    logic                   mem_to_reg;
    logic                   instr_retired;
    logic                   illegal_op;
  } ctrl_t;

endpackage

// File: rtl/main_ctrl_out_decode.sv
// Combinational state-to-control decoder for the multi-cycle main control unit.
// MAIN_CTRL_TRAP_EN enables decoding of the TRAP state.
module main_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl_c,
  output logic   pc_en_c
);

  logic branch_taken;

  always_comb begin
    ctrl_c       = '0;
    branch_taken = 1'b0;
    case (state)
      S_RESET: ctrl_c.op_class = OP_CLASS_RS;
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = ALU_B_FOUR;
        ctrl_c.op_class  = OP_CLASS_IF;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl_c.alu_src_b = ALU_B_SHIFT;
        ctrl_c.op_class  = OP_CLASS_ID;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ALU_B_SEXT;
        ctrl_c.op_class  = OP_CLASS_I;
      end
      S_MEMRD: begin
        ctrl_c.i_or_d   = 1'b1;
        ctrl_c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c.mem_to_reg    = 1'b1;
        ctrl_c.reg_write     = 1'b1;
        ctrl_c.instr_retired = 1'b1;
      end
      // Store retires only in the cycle memory accepts it
      S_MEMWR: begin
        ctrl_c.i_or_d        = 1'b1;
        ctrl_c.mem_write     = 1'b1;
        ctrl_c.instr_retired = mem_ready;
      end
      S_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.op_class  = OP_CLASS_R;
      end
      S_RWB: begin
        ctrl_c.reg_dst       = 1'b1;
        ctrl_c.reg_write     = 1'b1;
        ctrl_c.instr_retired = 1'b1;
      end
      S_ADDIWB: begin
        ctrl_c.reg_write     = 1'b1;
        ctrl_c.instr_retired = 1'b1;
      end
      S_BEQ, S_BNE: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PC_SRC_ALUOUT;
        ctrl_c.op_class      = OP_CLASS_BR;
        ctrl_c.instr_retired = 1'b1;
        branch_taken         = (state == S_BNE) ? !zero : zero;
      end
      S_JUMP: begin
        ctrl_c.pc_write      = 1'b1;
        ctrl_c.pc_source     = PC_SRC_JUMP;
        ctrl_c.op_class      = OP_CLASS_J;
        ctrl_c.instr_retired = 1'b1;
      end
`ifdef MAIN_CTRL_TRAP_EN
      S_TRAP: begin
        ctrl_c.op_class   = OP_CLASS_RS;
        ctrl_c.illegal_op = 1'b1;
      end
`endif
      default: ctrl_c.op_class = OP_CLASS_RS;
    endcase
  end

  assign pc_en_c = ctrl_c.pc_write | (ctrl_c.pc_write_cond & branch_taken);

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control: state register, next-state logic, datapath controls.
// Define MAIN_CTRL_TRAP_EN to trap illegal opcodes in a sticky TRAP state.
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [2:0]         op_class,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_en,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               instr_retired,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  logic   pc_en_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPCODE_LW, OPCODE_SW: state_d = S_MEMADR;
          OPCODE_RTYPE:         state_d = S_EXEC;
          OPCODE_ADDI:          state_d = S_ADDIEX;
          OPCODE_BEQ:           state_d = S_BEQ;
          OPCODE_BNE:           state_d = S_BNE;
          OPCODE_J:             state_d = S_JUMP;
`ifdef MAIN_CTRL_TRAP_EN
          default:              state_d = S_TRAP;
`else
          default:              state_d = S_FETCH;
`endif
        endcase
      end
      // Opcode is still held from DECODE, so it selects load vs store here
      S_MEMADR: state_d = (opcode == OPCODE_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BEQ, S_BNE, S_JUMP: state_d = S_FETCH;
`ifdef MAIN_CTRL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_RESET;
    endcase
  end

  main_ctrl_out_decode u_out_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl_c    (ctrl),
    .pc_en_c   (pc_en_c)
  );

  assign op_class      = ctrl.op_class;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_en         = pc_en_c;
  assign pc_source     = ctrl.pc_source;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign instr_retired = ctrl.instr_retired;
  assign illegal_op    = ctrl.illegal_op;
  assign state_o       = STATE_W'(state_q);

endmodule
